// File: rtl/image_stream_gen.sv
// Synthetic image-stream source: frames of FRAME_START, header, rows of
// ROW_START/pixels/ROW_END and FRAME_END carrying selectable test patterns.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 2
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 3
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 5
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 6
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 7
`endif
`ifndef Image_num_cols
`define Image_num_cols 1
`endif
`ifndef Image_num_rows
`define Image_num_rows 2
`endif

module image_stream_gen #(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int HEADER_LEN  = 32,
    parameter int DTYPE_WIDTH = `DTYPE_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  num_cols,
    input  logic [DATA_WIDTH-1:0]  num_rows,
    input  logic [DATA_WIDTH-1:0]  row_gap,
    input  logic [1:0]             pattern,
    input  logic [PIXEL_WIDTH-1:0] const_value,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [PIXEL_WIDTH-1:0] datao,
    output logic [DATA_WIDTH-1:0]  meta_datao,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  frame_count
);

    localparam int HW = 7;

    localparam logic [DTYPE_WIDTH-1:0] DT_FS = DTYPE_WIDTH'(`DTYPE_FRAME_START);
    localparam logic [DTYPE_WIDTH-1:0] DT_FE = DTYPE_WIDTH'(`DTYPE_FRAME_END);
    localparam logic [DTYPE_WIDTH-1:0] DT_HS = DTYPE_WIDTH'(`DTYPE_HEADER_START);
    localparam logic [DTYPE_WIDTH-1:0] DT_HD = DTYPE_WIDTH'(`DTYPE_HEADER);
    localparam logic [DTYPE_WIDTH-1:0] DT_RS = DTYPE_WIDTH'(`DTYPE_ROW_START);
    localparam logic [DTYPE_WIDTH-1:0] DT_RE = DTYPE_WIDTH'(`DTYPE_ROW_END);
    localparam logic [DTYPE_WIDTH-1:0] DT_PX = DTYPE_WIDTH'(`DTYPE_PIXEL);

    localparam logic [HW-1:0] H_COLS = HW'(`Image_num_cols);
    localparam logic [HW-1:0] H_ROWS = HW'(`Image_num_rows);
    localparam logic [HW-1:0] H_LAST = HW'(HEADER_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FSTART,
        S_HSTART,
        S_HDR,
        S_RSTART,
        S_PIX,
        S_REND,
        S_RGAP,
        S_FEND
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  cols_q;
    logic [DATA_WIDTH-1:0]  rows_q;
    logic [DATA_WIDTH-1:0]  gap_q;
    logic [1:0]             pat_q;
    logic [PIXEL_WIDTH-1:0] cval_q;
    logic [DATA_WIDTH-1:0]  col_q;
    logic [DATA_WIDTH-1:0]  row_q;
    logic [DATA_WIDTH-1:0]  gcnt_q;
    logic [HW-1:0]          hdr_q;
    logic                   busy_q;
    logic [DATA_WIDTH-1:0]  fcnt_q;
    logic                   dv_q;
    logic [DTYPE_WIDTH-1:0] dt_q;
    logic [PIXEL_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0]  meta_q;

    logic [DATA_WIDTH-1:0]  sum_cr;
    logic [DATA_WIDTH-1:0]  sum_cf;
    logic [PIXEL_WIDTH-1:0] pix_d;
    logic [DATA_WIDTH-1:0]  meta_d;
    logic                   last_col;
    logic                   last_row;
    logic                   last_hdr;
    logic                   last_gap;
    logic                   go;

    assign sum_cr   = col_q + row_q;
    assign sum_cf   = col_q + fcnt_q;
    assign last_col = (col_q == cols_q - DATA_WIDTH'(1));
    assign last_row = (row_q == rows_q - DATA_WIDTH'(1));
    assign last_gap = (gcnt_q == gap_q - DATA_WIDTH'(1));
    assign last_hdr = (hdr_q == H_LAST);
    assign go = enable && start && (num_cols != '0) && (num_rows != '0);

    always_comb begin
        pix_d = '0;
        unique case (pat_q)
            2'd0: pix_d = sum_cr[PIXEL_WIDTH-1:0];
            2'd1: pix_d = cval_q;
            2'd2: pix_d = {PIXEL_WIDTH{col_q[0] ^ row_q[0]}};
            2'd3: pix_d = sum_cf[PIXEL_WIDTH-1:0];
            default: pix_d = '0;
        endcase
    end

    always_comb begin
        meta_d = '0;
        if (hdr_q == H_COLS) begin
            meta_d = cols_q;
        end else if (hdr_q == H_ROWS) begin
            meta_d = rows_q;
        end else if (hdr_q == '0) begin
            meta_d = fcnt_q;
        end
    end

    // Beat outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            cols_q  <= '0;
            rows_q  <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
            cval_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            gcnt_q  <= '0;
            hdr_q   <= '0;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
            dv_q    <= 1'b0;
            dt_q    <= '0;
            data_q  <= '0;
            meta_q  <= '0;
        end else begin
            dv_q   <= 1'b0;
            dt_q   <= '0;
            data_q <= '0;
            meta_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        cols_q  <= num_cols;
                        rows_q  <= num_rows;
                        gap_q   <= row_gap;
                        pat_q   <= pattern;
                        cval_q  <= const_value;
                        col_q   <= '0;
                        row_q   <= '0;
                        gcnt_q  <= '0;
                        hdr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FSTART;
                    end
                end
                S_FSTART: begin
                    dv_q    <= 1'b1;
                    dt_q    <= DT_FS;
                    state_q <= S_HSTART;
                end
                S_HSTART: begin
                    dv_q    <= 1'b1;
                    dt_q    <= DT_HS;
                    hdr_q   <= '0;
                    state_q <= S_HDR;
                end
                S_HDR: begin
                    dv_q   <= 1'b1;
                    dt_q   <= DT_HD;
                    meta_q <= meta_d;
                    if (last_hdr) begin
                        hdr_q   <= '0;
                        state_q <= S_RSTART;
                    end else begin
                        hdr_q <= hdr_q + HW'(1);
                    end
                end
                S_RSTART: begin
                    dv_q    <= 1'b1;
                    dt_q    <= DT_RS;
                    col_q   <= '0;
                    state_q <= S_PIX;
                end
                S_PIX: begin
                    dv_q   <= 1'b1;
                    dt_q   <= DT_PX;
                    data_q <= pix_d;
                    if (last_col) begin
                        state_q <= S_REND;
                    end else begin
                        col_q <= col_q + DATA_WIDTH'(1);
                    end
                end
                S_REND: begin
                    dv_q  <= 1'b1;
                    dt_q  <= DT_RE;
                    col_q <= '0;
                    if (last_row) begin
                        state_q <= S_FEND;
                    end else begin
                        row_q   <= row_q + DATA_WIDTH'(1);
                        gcnt_q  <= '0;
                        state_q <= (gap_q != '0) ? S_RGAP : S_RSTART;
                    end
                end
                S_RGAP: begin
                    if (last_gap) begin
                        state_q <= S_RSTART;
                    end else begin
                        gcnt_q <= gcnt_q + DATA_WIDTH'(1);
                    end
                end
                S_FEND: begin
                    dv_q    <= 1'b1;
                    dt_q    <= DT_FE;
                    busy_q  <= 1'b0;
                    fcnt_q  <= fcnt_q + DATA_WIDTH'(1);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dvo         = dv_q;
    assign dtypeo      = dt_q;
    assign datao       = data_q;
    assign meta_datao  = meta_q;
    assign busy        = busy_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_image_stream_gen.sv
// Scoreboard bench for image_stream_gen: expected beats are queued by the
// stimulus process and popped by an independent monitor on dvo.

module tb_image_stream_gen;

    localparam int DT_FS = 1;
    localparam int DT_FE = 2;
    localparam int DT_HS = 3;
    localparam int DT_HD = 4;
    localparam int DT_RS = 5;
    localparam int DT_RE = 6;
    localparam int DT_PX = 7;

    typedef struct packed {
        logic [3:0]  dt;
        logic [9:0]  d;
        logic [15:0] m;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_cols = '0;
    logic [15:0] num_rows = '0;
    logic [15:0] row_gap = '0;
    logic [1:0]  pattern = '0;
    logic [9:0]  const_value = '0;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [9:0]  datao;
    logic [15:0] meta_datao;
    logic        busy;
    logic [15:0] frame_count;

    beat_t q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    exp_gap = 0;

    always #5 clk = ~clk;

    image_stream_gen dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (enable),
        .start      (start),
        .num_cols   (num_cols),
        .num_rows   (num_rows),
        .row_gap    (row_gap),
        .pattern    (pattern),
        .const_value(const_value),
        .dvo        (dvo),
        .dtypeo     (dtypeo),
        .datao      (datao),
        .meta_datao (meta_datao),
        .busy       (busy),
        .frame_count(frame_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] pix(input int pat, input int c,
                                       input int r, input int cv,
                                       input int fc);
        logic [9:0] v;
        case (pat)
            0: v = 10'((c + r) & 32'h3ff);
            1: v = 10'(cv);
            2: v = ((c ^ r) & 1) != 0 ? 10'h3ff : 10'h000;
            default: v = 10'((c + fc) & 32'h3ff);
        endcase
        return v;
    endfunction

    task automatic push_frame(input int cols, input int rows, input int pat,
                              input int cv, input int fc);
        beat_t b;
        b = '{dt: 4'(DT_FS), d: '0, m: '0};
        q.push_back(b);
        b.dt = 4'(DT_HS);
        q.push_back(b);
        for (int h = 0; h < 32; h++) begin
            b.dt = 4'(DT_HD);
            b.m  = (h == 1) ? 16'(cols) : (h == 2) ? 16'(rows) :
                   (h == 0) ? 16'(fc) : 16'h0;
            q.push_back(b);
        end
        b.m = '0;
        for (int r = 0; r < rows; r++) begin
            b.dt = 4'(DT_RS);
            b.d  = '0;
            q.push_back(b);
            for (int c = 0; c < cols; c++) begin
                b.dt = 4'(DT_PX);
                b.d  = pix(pat, c, r, cv, fc);
                q.push_back(b);
            end
            b.dt = 4'(DT_RE);
            b.d  = '0;
            q.push_back(b);
        end
        b.dt = 4'(DT_FE);
        q.push_back(b);
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 32'(n < 3000), 32'd1);
        chk({name, "_left"}, 32'(q.size()), 32'd0);
    endtask

    // Monitor: beat contents plus idle-cycle spacing after each ROW_END.
    initial begin : monitor
        beat_t e;
        bit    seen_re;
        int    idle;
        seen_re = 1'b0;
        idle = 0;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                seen_re = 1'b0;
            end else if (dvo) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {28'h0, dtypeo}, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("beat", {2'b0, dtypeo, datao, meta_datao}, {2'b0, e});
                end
                if (seen_re && dtypeo == 4'(DT_RS))
                    chk("row_gap", 32'(idle), 32'(exp_gap));
                if (seen_re && dtypeo == 4'(DT_FE))
                    chk("last_gap", 32'(idle), 32'd0);
                seen_re = (dtypeo == 4'(DT_RE));
                idle = 0;
            end else begin
                idle++;
                if (dtypeo != '0 || datao != '0 || meta_datao != '0)
                    chk("idle_zero", {dtypeo, datao, meta_datao}, 32'h0);
            end
        end
    end

    initial begin : stim
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dvo", 32'(dvo), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_dtype", 32'(dtypeo), 32'd0);
        resetb = 1'b1;

        // 1: 4x3 ramp
        num_cols = 16'd4; num_rows = 16'd3; row_gap = '0; pattern = 2'd0;
        exp_gap = 0;
        push_frame(4, 3, 0, 0, 0);
        kick();
        wait_done("t1");
        chk("t1_fc", 32'(frame_count), 32'd1);

        // 2: row gap 5, constant
        num_cols = 16'd2; num_rows = 16'd2; row_gap = 16'd5; pattern = 2'd1;
        const_value = 10'h2a5;
        exp_gap = 5;
        push_frame(2, 2, 1, 'h2a5, 1);
        kick();
        wait_done("t2");

        // 3: zero size ignored, then a 1x1 frame
        num_cols = '0; num_rows = 16'd3; row_gap = '0; pattern = 2'd3;
        exp_gap = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || dvo) chk("t3_idle", {busy, dvo}, 32'h0);
        end
        chk("t3_busy", 32'(busy), 32'd0);
        num_cols = 16'd1; num_rows = 16'd1;
        push_frame(1, 1, 3, 0, 2);
        @(negedge clk);
        start = 1'b0;
        chk("t3_busy_go", 32'(busy), 32'd1);
        wait_done("t3");
        chk("t3_fc", 32'(frame_count), 32'd3);

        // 4: mid-frame changes are ignored; held start waits for enable
        num_cols = 16'd3; num_rows = 16'd2; pattern = 2'd0;
        push_frame(3, 2, 0, 0, 3);
        kick();
        repeat (20) @(negedge clk);
        enable = 1'b0;
        num_cols = 16'd7;
        start = 1'b1;
        wait_done("t4a");
        repeat (10) @(negedge clk);
        chk("t4_hold_busy", 32'(busy), 32'd0);
        chk("t4_fc", 32'(frame_count), 32'd4);
        push_frame(7, 2, 0, 0, 4);
        enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_go", 32'(busy), 32'd1);
        wait_done("t4b");

        // 5: asynchronous reset in the middle of a row
        num_cols = 16'd8; num_rows = 16'd4; pattern = 2'd0;
        push_frame(8, 4, 0, 0, 5);
        kick();
        begin
            int n;
            n = 0;
            while (!(dvo && dtypeo == 4'(DT_PX)) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("t5_reach_pix", 32'(n < 200), 32'd1);
        end
        #2 resetb = 1'b0;
        #1;
        chk("t5_dvo", 32'(dvo), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_dtype", 32'(dtypeo), 32'd0);
        q.delete();
        @(negedge clk);
        resetb = 1'b1;
        chk("t5_fc_clr", 32'(frame_count), 32'd0);
        num_cols = 16'd2; num_rows = 16'd2; pattern = 2'd3;
        push_frame(2, 2, 3, 0, 0);
        kick();
        wait_done("t5");
        chk("t5_fc", 32'(frame_count), 32'd1);

        // 6: 8x6 checkerboard with one-cycle row gaps
        num_cols = 16'd8; num_rows = 16'd6; row_gap = 16'd1; pattern = 2'd2;
        exp_gap = 1;
        push_frame(8, 6, 2, 0, 1);
        kick();
        wait_done("t6");
        chk("t6_fc", 32'(frame_count), 32'd2);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
